// File: rtl/number_feeder_pkg.sv
// Shared types and constants for the number feeder and its analyzer interface.
package number_feeder_pkg;
    localparam int ANA_WIDTH          = 32;
    localparam int RESULT_LATENCY_DEF = 2;
    localparam int LAT_CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // WAIT lasts RESULT_LATENCY-1 cycles; the timer expires when it reaches zero.
    function automatic logic [LAT_CNT_W-1:0] wait_load(input int lat);
        return (lat >= 2) ? LAT_CNT_W'(lat - 2) : '0;
    endfunction
endpackage

// File: rtl/number_feeder_if.sv
// go/number/result analyzer interface; master = feeder, slave = analyzer.
interface number_feeder_if #(
    parameter int WIDTH = number_feeder_pkg::ANA_WIDTH
);
    logic             ana_reset;
    logic             ana_go;
    logic [WIDTH-1:0] ana_number;
    logic             ana_result;

    modport master (output ana_reset, output ana_go, output ana_number, input ana_result);
    modport slave  (input ana_reset, input ana_go, input ana_number, output ana_result);
endinterface

// File: rtl/number_feeder_latency_timer.sv
// Loadable 4-bit down-counter that flags the end of the analyzer WAIT window.
module feeder_latency_timer
    import number_feeder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 expired_o
);
    logic [LAT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/number_feeder.sv
// Sweeps an inclusive operand range through one analyzer and counts flagged results.
// Optional last_hit output is built when FEEDER_LAST_HIT_EN is defined.
module number_feeder
    import number_feeder_pkg::*;
#(
    parameter int WIDTH          = ANA_WIDTH,
    parameter int RESULT_LATENCY = RESULT_LATENCY_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] first_i,
    input  logic [WIDTH-1:0] last_i,
    number_feeder_if.master  ana,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   hit_count,
    output logic [WIDTH:0]   total_count
`ifdef FEEDER_LAST_HIT_EN
    ,output logic [WIDTH-1:0] last_hit
`endif
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d, lim_q, lim_d;
    logic [WIDTH:0]   hit_q, hit_d, total_q, total_d;
    logic             ana_reset_q, ana_go_q, busy_q, done_q;
    logic             lat_expired;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && start_i;

    feeder_latency_timer u_lat (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (wait_load(RESULT_LATENCY)),
        .en_i       (state_q == ST_WAIT),
        .expired_o  (lat_expired)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        lim_d   = lim_q;
        hit_d   = hit_q;
        total_d = total_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                cur_d   = first_i;
                lim_d   = last_i;
                hit_d   = '0;
                total_d = '0;
                state_d = (first_i > last_i) ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_ISSUE;
            ST_ISSUE: state_d = (RESULT_LATENCY == 1) ? ST_SAMPLE : ST_WAIT;
            ST_WAIT:  if (lat_expired) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                total_d = total_q + 1'b1;
                hit_d   = hit_q + (WIDTH+1)'(ana.ana_result);
                // Compare before incrementing so a sweep ending at all-ones never wraps.
                if (cur_q == lim_q) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            lim_q       <= '0;
            hit_q       <= '0;
            total_q     <= '0;
            ana_reset_q <= 1'b1;
            ana_go_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            lim_q       <= lim_d;
            hit_q       <= hit_d;
            total_q     <= total_d;
            ana_reset_q <= (state_d == ST_CLEAR);
            ana_go_q    <= (state_d == ST_ISSUE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

`ifdef FEEDER_LAST_HIT_EN
    logic [WIDTH-1:0] last_hit_q;

    always_ff @(posedge clock) begin
        if (!reset || accept) begin
            last_hit_q <= '0;
        end else if ((state_q == ST_SAMPLE) && ana.ana_result) begin
            last_hit_q <= cur_q;
        end
    end

    assign last_hit = last_hit_q;
`endif

    assign ana.ana_reset  = ana_reset_q;
    assign ana.ana_go     = ana_go_q;
    assign ana.ana_number = cur_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign hit_count      = hit_q;
    assign total_count    = total_q;
endmodule

// File: tb/tb_number_feeder.sv
// Randomized sweeps against a schedule/count model, with an even-number analyzer model.
module tb_number_feeder;
    localparam int W   = 32;
    localparam int L   = 2;
    localparam int PER = L + 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start_i = 1'b0;
    logic [W-1:0]   first_i = '0;
    logic [W-1:0]   last_i = '0;
    logic           busy, done;
    logic [W:0]     hit_count, total_count;
`ifdef FEEDER_LAST_HIT_EN
    logic [W-1:0]   last_hit;
`endif

    number_feeder_if #(.WIDTH(W)) ana ();

    number_feeder #(.WIDTH(W), .RESULT_LATENCY(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .first_i     (first_i),
        .last_i      (last_i),
        .ana         (ana),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count),
        .total_count (total_count)
`ifdef FEEDER_LAST_HIT_EN
        ,.last_hit   (last_hit)
`endif
    );

    always #5 clock = ~clock;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;

    // sweep model
    bit      rst_seen = 1'b1;
    bit      active = 1'b0;
    longint  acc, n_ops;
    logic [W-1:0] m_first;
    longint  exp_hit, exp_lh;
    longint  held_hit = 0, held_total = 0, held_lh = 0;

    // analyzer model
    longint  pend_cyc = -1;
    bit      pend_val;
    logic    prev_clr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic longint evens(input longint a, input longint b);
        return (b / 2) - ((a + 1) / 2) + 1;
    endfunction

    // Even checker: result valid exactly L cycles after the go cycle, noise otherwise.
    always @(posedge clock) begin
        if (ana.ana_go === 1'b1) begin
            chk("clr_before_go", 64'(prev_clr), 64'd1);
            pend_cyc = cyc + L;
            pend_val = ~ana.ana_number[0];
        end
        prev_clr = ana.ana_reset;
        rst_seen = !reset;
        if (!reset) begin
            active     = 1'b0;
            held_hit   = 0;
            held_total = 0;
            held_lh    = 0;
            pend_cyc   = -1;
        end
        cyc++;
        #1 ana.ana_result = (cyc == pend_cyc) ? pend_val : 1'($urandom_range(0, 1));
    end

    always @(negedge clock) begin
        longint rel, span;
        logic [W-1:0] en;
        if (rst_seen) begin
            chk("rst_ana_reset", 64'(ana.ana_reset), 64'd1);
            chk("rst_go", 64'(ana.ana_go), 64'd0);
            chk("rst_number", 64'(ana.ana_number), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_hit", 64'(hit_count), 64'd0);
            chk("rst_total", 64'(total_count), 64'd0);
`ifdef FEEDER_LAST_HIT_EN
            chk("rst_last_hit", 64'(last_hit), 64'd0);
`endif
        end else if (active && cyc > acc) begin
            rel  = cyc - acc - 1;
            span = n_ops * PER;
            chk("go", 64'(ana.ana_go), 64'(rel < span && rel % PER == 1));
            chk("ana_reset", 64'(ana.ana_reset), 64'(rel < span && rel % PER == 0));
            chk("busy", 64'(busy), 64'(rel <= span));
            chk("done", 64'(done), 64'(rel == span));
            if (rel < span && rel % PER == 1) begin
                en = m_first + W'(rel / PER);
                chk("number", 64'(ana.ana_number), 64'(en));
            end
            if (rel == span) begin
                chk("hit_at_done", 64'(hit_count), 64'(exp_hit));
                chk("total_at_done", 64'(total_count), 64'(n_ops));
`ifdef FEEDER_LAST_HIT_EN
                chk("last_hit_at_done", 64'(last_hit), 64'(exp_lh));
`endif
                held_hit   = exp_hit;
                held_total = n_ops;
                held_lh    = exp_lh;
                active     = 1'b0;
            end
        end else if (active) begin
            chk("busy_pre", 64'(busy), 64'd0);
            chk("done_pre", 64'(done), 64'd0);
        end else begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_go", 64'(ana.ana_go), 64'd0);
            chk("idle_ana_reset", 64'(ana.ana_reset), 64'd0);
            chk("idle_hit", 64'(hit_count), 64'(held_hit));
            chk("idle_total", 64'(total_count), 64'(held_total));
`ifdef FEEDER_LAST_HIT_EN
            chk("idle_last_hit", 64'(last_hit), 64'(held_lh));
`endif
        end
    end

    task automatic start_sweep(input logic [W-1:0] a, input logic [W-1:0] b);
        longint la, lb;
        @(negedge clock);
        start_i = 1'b1;
        first_i = a;
        last_i  = b;
        la = longint'(a);
        lb = longint'(b);
        m_first = a;
        acc     = cyc;
        if (la > lb) begin
            n_ops = 0; exp_hit = 0; exp_lh = 0;
        end else begin
            n_ops   = lb - la + 1;
            exp_hit = evens(la, lb);
            exp_lh  = (lb % 2 == 0) ? lb : ((lb - 1 >= la) ? lb - 1 : 0);
        end
        active = 1'b1;
    endtask

    task automatic wait_done(input int inj, output longint lat);
        @(negedge clock);
        start_i = 1'b0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin
                lat = cyc - acc;
                break;
            end
            if (i == inj) begin
                start_i = 1'b1;
                first_i = $urandom;
                last_i  = first_i + 3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clock);
        end
        start_i = 1'b0;
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clock);
    endtask

    initial begin
        longint lat;
        logic [W-1:0] a, b;
        int mode, len, inj;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        start_sweep(32'd4, 32'd7);
        wait_done(-1, lat);
        chk("lat_4_7", 64'(lat), 64'd17);
        chk("hit_4_7", 64'(hit_count), 64'd2);
        chk("total_4_7", 64'(total_count), 64'd4);

        start_sweep(32'd9, 32'd3);
        wait_done(-1, lat);
        chk("lat_empty", 64'(lat), 64'd1);
        chk("hit_empty", 64'(hit_count), 64'd0);
        chk("total_empty", 64'(total_count), 64'd0);

        start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_done(-1, lat);
        chk("lat_top", 64'(lat), 64'd9);
        chk("hit_top", 64'(hit_count), 64'd1);
        chk("total_top", 64'(total_count), 64'd2);

        start_sweep(32'd10, 32'd15);
        wait_done(5, lat);
        chk("hit_inject", 64'(hit_count), 64'd3);
        chk("total_inject", 64'(total_count), 64'd6);

`ifdef FEEDER_LAST_HIT_EN
        start_sweep(32'd1, 32'd6);
        wait_done(-1, lat);
        chk("last_hit_1_6", 64'(last_hit), 64'd6);
        chk("hit_1_6", 64'(hit_count), 64'd3);
`endif

        // Reset during WAIT of the second operand of 0..9.
        start_sweep(32'd0, 32'd9);
        @(negedge clock);
        start_i = 1'b0;
        while (cyc < acc + 7) @(negedge clock);
        chk("wait_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ana_reset", 64'(ana.ana_reset), 64'd1);
        chk("midrst_total", 64'(total_count), 64'd0);
        reset = 1'b1;
        repeat (45) @(negedge clock);

        for (int k = 0; k < 20; k++) begin
            mode = $urandom_range(0, 3);
            a = $urandom;
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1;
            if (mode == 0) begin
                if (a < 32'd20) a = a + 32'd20;
                b = a - W'($urandom_range(1, 15));
            end else if (mode == 1) begin
                a = 32'hFFFF_FFFF - W'($urandom_range(0, 6));
                b = 32'hFFFF_FFFF;
            end else begin
                len = $urandom_range(1, 12);
                b = (longint'(a) + len - 1 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : a + W'(len - 1);
            end
            start_sweep(a, b);
            wait_done(inj, lat);
            chk("rand_lat", 64'(lat), 64'(n_ops * PER + 1));
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/number_feeder.md
# number_feeder

Drives the go/number/result analyzer interface from the initiator side. It sweeps an inclusive range of operands through one attached number analyzer, such as the even-number checker, and returns the analyzer to its initial state between operands. It counts the operands the analyzer flags and pulses done at the end of the sweep. It sits between the top-level control and any single-result analyzer in the NumberAnalyzer design.

## Interface
- WIDTH, 32, operand width
- RESULT_LATENCY, 2, cycles from the go cycle to a valid result (2 for the even checker); legal range 1..15
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- start_i  input  1  begin sweep; sampled only in IDLE
- first_i  input  WIDTH  first operand; captured on start
- last_i  input  WIDTH  last operand, inclusive; captured on start
- ana_result  input  1  analyzer result bit
- ana_reset  output  1  active-high reset to the analyzer
- ana_go  output  1  go strobe to the analyzer
- ana_number  output  WIDTH  operand to the analyzer; held stable from ISSUE through SAMPLE
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at sweep end
- hit_count  output  WIDTH+1  number of operands that returned result = 1
- total_count  output  WIDTH+1  number of operands issued
- last_hit  output  WIDTH  most recent flagged operand; present only with the macro

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT, SAMPLE, DONE.
- All outputs are Moore outputs, decoded from registered state.
- IDLE: when start_i = 1, the block does the following:
  - captures first_i into cur and last_i into lim
  - clears both counts
  - goes to DONE if first_i > last_i (unsigned), otherwise to CLEAR
- CLEAR: ana_reset = 1 for one cycle, then ISSUE.
- ISSUE: ana_go = 1 and ana_number = cur for one cycle, then WAIT.
- WAIT: stays for RESULT_LATENCY-1 cycles using a latency counter, then SAMPLE.
  - With RESULT_LATENCY = 1, WAIT is skipped.
- SAMPLE: the block samples ana_result.
  - total_count increments by 1.
  - hit_count increments by 1 if ana_result = 1.
  - If cur == lim, the next state is DONE. Otherwise cur increments by 1 and the next state is CLEAR.
- DONE: done = 1 for one cycle, then IDLE. The counts hold until the next accepted start.
- start_i asserted outside IDLE is ignored.
- Termination compares cur against lim before incrementing, so cur never wraps. A sweep ending at 2^WIDTH-1 ends cleanly.
- Counts are WIDTH+1 bits wide. The full range 0..2^WIDTH-1 therefore gives total_count = 2^WIDTH without overflow.

## Timing
- Reset values:
  - state = IDLE
  - ana_reset = 1 (the analyzer is held in reset while the feeder is in reset)
  - ana_go = 0, ana_number = 0
  - busy = 0, done = 0
  - hit_count = 0, total_count = 0, last_hit = 0
- After reset deasserts, ana_reset = 0 in IDLE.
- Start accepted at edge E: CLEAR is the cycle after E. ISSUE occurs at cycle t. SAMPLE occurs at t+RESULT_LATENCY.
- Each operand takes RESULT_LATENCY+2 cycles (4 at the default).
- Sweep of N operands: done is high N*(RESULT_LATENCY+2)+1 cycles after the accept edge.
- Empty range: done is high in the cycle after the accept edge. The analyzer sees no ana_go. busy is high for that one cycle.
- Reset asserted mid-sweep: on the next edge, everything returns to reset values and no done pulse is produced. A partial count is discarded.

## Configuration
- FEEDER_LAST_HIT_EN defined:
  - last_hit port and register are present.
  - last_hit loads cur in SAMPLE when ana_result = 1.
  - last_hit clears on reset and on an accepted start.
- Not defined: the port and register are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (3-bit encoding of the six states)
  - the RESULT_LATENCY default constant
  - the analyzer-interface width constant (32)
- Sub-module: feeder_latency_timer. It is a loadable down-counter, 4 bits wide, that signals WAIT expiry. It keeps the latency logic out of the FSM.

## Test plan
- Range 4..7, even-checker model at latency 2: hit_count = 2, total_count = 4, and done arrives 17 cycles after the accept edge. Each ana_go is preceded by one ana_reset cycle.
- first = 9, last = 3: done pulses in the cycle after the accept edge, with no ana_go and both counts 0.
- first = 0xFFFFFFFE, last = 0xFFFFFFFF: total_count = 2 and hit_count = 1, with no wrap and no extra issue.
- Reset driven to 0 during the WAIT of the second operand of range 0..9: all outputs return to reset values on the next edge, ana_reset = 1, and no done pulse occurs.
- start_i asserted mid-sweep with different first/last values: it is ignored, and the counts match the original range only.
- With FEEDER_LAST_HIT_EN, range 1..6 on the even model: last_hit = 6. Without the macro, the build has no last_hit port.
